// File: rtl/dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : dmem_loader
// Description : Sequential write-side initiator for the single-cycle core's
//               32-word data memory. Streams words from a valid/ready source
//               into consecutive slots starting at a programmable base,
//               wrapping modulo 32. It can optionally read the slots back and
//               compare an XOR checksum of what was read against an XOR
//               checksum of what was written.
//
// Build option: DMEM_LOADER_VERIFY_EN
//               defined   -> VERIFY state, read-back checksum, mismatch flag
//               undefined -> LOAD goes straight to DONE, memRead = 0,
//                            mismatch = 0, dataOut ignored
//
// Ports:
//   clk       in   1   rising-edge clock, shared with the data memory
//   reset     in   1   asynchronous, active-low reset
//   start     in   1   begin a load (sampled only while idle)
//   base      in   5   first slot index, sampled with start
//   len       in   6   word count, sampled with start (33..63 clamp to 32)
//   in_valid  in   1   source word valid
//   in_data   in  32   source word
//   in_ready  out  1   loader accepts in_data this cycle
//   memWrite  out  1   write strobe to data memory
//   memRead   out  1   read strobe to data memory
//   addr      out 32   {27'b0, slot pointer}
//   data      out 32   write data (in_data while writing, else 0)
//   dataOut   in  32   combinational read data from data memory
//   busy      out  1   high whenever the loader is not idle
//   done      out  1   one-cycle pulse at the end of a load
//   mismatch  out  1   read-back checksum failure, sticky until next start
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  base,
    input  logic [5:0]  len,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        memWrite,
    output logic        memRead,
    output logic [31:0] addr,
    output logic [31:0] data,
    input  logic [31:0] dataOut,
    output logic        busy,
    output logic        done,
    output logic        mismatch
);

    // The slot pointer is a 5-bit index; DEPTH is only ever 32.
    localparam int          c_PTR_W   = 5;
    localparam logic [5:0]  c_MAX_LEN = 6'(DEPTH);

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_LOAD   = 2'd1,
        c_VERIFY = 2'd2,
        c_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_base_q;
    logic [5:0]           r_len_q;
    logic [5:0]           r_cnt;
    logic [31:0]          r_csum;
`ifdef DMEM_LOADER_VERIFY_EN
    logic [31:0]          r_rsum;
    logic                 r_mismatch;
`endif

    logic                 w_wr;
    logic                 w_last;
    logic [5:0]           w_len_clamped;

    // A handshake happens whenever the source is valid while loading; the
    // memory captures the write on the same edge.
    assign w_wr          = (r_state == c_LOAD) && in_valid;
    // r_len_q is never 0 in LOAD/VERIFY (len = 0 skips straight to DONE),
    // so the subtraction cannot underflow where it matters.
    assign w_last        = (r_cnt == (r_len_q - 6'd1));
    assign w_len_clamped = (len > c_MAX_LEN) ? c_MAX_LEN : len;

    // ------------------------------------------------------------------
    // Output decode (combinational from state and registers)
    // ------------------------------------------------------------------
    assign in_ready = (r_state == c_LOAD);
    assign memWrite = w_wr;
    assign data     = w_wr ? in_data : 32'd0;
    assign addr     = {{(32-c_PTR_W){1'b0}}, r_ptr};
    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);

`ifdef DMEM_LOADER_VERIFY_EN
    assign memRead  = (r_state == c_VERIFY);
    assign mismatch = r_mismatch;
`else
    assign memRead  = 1'b0;
    assign mismatch = 1'b0;

    // Read data and the saved base only matter for read-back.
    logic w_unused;
    assign w_unused = ^{dataOut, r_base_q};
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_base_q   <= '0;
            r_len_q    <= '0;
            r_cnt      <= '0;
            r_csum     <= '0;
`ifdef DMEM_LOADER_VERIFY_EN
            r_rsum     <= '0;
            r_mismatch <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ptr      <= base;
                        r_base_q   <= base;
                        r_len_q    <= w_len_clamped;
                        r_cnt      <= '0;
                        r_csum     <= '0;
`ifdef DMEM_LOADER_VERIFY_EN
                        r_mismatch <= 1'b0;
`endif
                        r_state    <= (w_len_clamped == 6'd0) ? c_DONE : c_LOAD;
                    end
                end

                c_LOAD: begin
                    if (w_wr) begin
                        r_csum <= r_csum ^ in_data;
                        r_ptr  <= r_ptr + 5'd1;
                        r_cnt  <= r_cnt + 6'd1;
                        if (w_last) begin
`ifdef DMEM_LOADER_VERIFY_EN
                            // Rewind to the first slot for read-back.
                            r_state <= c_VERIFY;
                            r_ptr   <= r_base_q;
                            r_cnt   <= '0;
                            r_rsum  <= '0;
`else
                            r_state <= c_DONE;
`endif
                        end
                    end
                end

                c_VERIFY: begin
`ifdef DMEM_LOADER_VERIFY_EN
                    r_rsum <= r_rsum ^ dataOut;
                    r_ptr  <= r_ptr + 5'd1;
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        // Fold in the final read word, which r_rsum has not
                        // absorbed yet on this edge.
                        r_state    <= c_DONE;
                        r_mismatch <= ((r_rsum ^ dataOut) != r_csum);
                    end
`else
                    r_state <= c_IDLE;
`endif
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_loader
// Description : Directed self-checking bench for dmem_loader with a
//               behavioural 32-word data memory. Adapts its expectations to
//               whether DMEM_LOADER_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_loader;

`ifdef DMEM_LOADER_VERIFY_EN
    localparam bit c_VERIFY = 1'b1;
`else
    localparam bit c_VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  base;
    logic [5:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        memWrite;
    logic        memRead;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;
    logic        mismatch;

    always #5 clk = ~clk;

    dmem_loader #(.DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .memWrite(memWrite), .memRead(memRead), .addr(addr), .data(data),
        .dataOut(dataOut), .busy(busy), .done(done), .mismatch(mismatch)
    );

    // Behavioural data memory: synchronous write, combinational read.
    logic [31:0] mem [0:31];
    logic        mem_clr;
    logic        force_en;
    logic [4:0]  force_idx;
    logic [31:0] force_val;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (memWrite) begin
            mem[addr[4:0]] <= data;
        end else if (force_en) begin
            mem[force_idx] <= force_val;
        end
    end
    assign dataOut = mem[addr[4:0]];

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations gathered by run_load
    int          lat, nwr, nrd, overlap, done_width;
    bit          timeout;
    logic [7:0]  wrseq;
    logic        mis_at_done, mis_after_start;
    logic [4:0]  wq[$];
    logic [4:0]  rq[$];
    logic [31:0] dq[$];

    task automatic clear_mem();
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0;
    endtask

    // Drives one load and records what the DUT does. t counts edges with the
    // start-sampling edge as 1, so done observed at t means start->done = t.
    task automatic run_load(input logic [4:0] b, input logic [5:0] l,
                            input bit toggle, input logic [31:0] w0,
                            input bit corrupt, input bit stray);
        int t;
        int widx;
        bit seen;
        bit fire;
        wq.delete(); rq.delete(); dq.delete();
        lat = 0; nwr = 0; nrd = 0; overlap = 0; done_width = 0;
        timeout = 1'b0; wrseq = '0; mis_at_done = 1'b0; mis_after_start = 1'b0;
        @(negedge clk);
        start = 1'b1; base = b; len = l; in_valid = 1'b0; in_data = '0;
        @(posedge clk);
        t = 1; widx = 0; seen = 1'b0;
        while (1) begin
            @(negedge clk);
            start    = 1'b0;
            force_en = 1'b0;
            if (stray && t == 2) begin
                start = 1'b1; base = 5'd20; len = 6'd3;
            end
            in_valid = toggle ? ((t % 2) == 1) : 1'b1;
            in_data  = w0 + 32'(widx);
            #1;
            if (t == 1) mis_after_start = mismatch;
            if (t <= 8) wrseq[t-1] = memWrite;
            fire = in_valid && in_ready;
            if (memWrite) begin
                nwr++; wq.push_back(addr[4:0]); dq.push_back(data);
            end
            if (memRead) begin
                nrd++; rq.push_back(addr[4:0]);
                if (corrupt && nrd == 1) begin
                    force_en = 1'b1; force_idx = 5'd1; force_val = 32'hDEAD_BEEF;
                end
            end
            if (memWrite && memRead) overlap++;
            if (done) begin
                done_width++;
                if (!seen) begin
                    seen = 1'b1; lat = t; mis_at_done = mismatch;
                end
            end else if (seen) begin
                break;
            end
            if (t > 200) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            if (fire) widx++;
            t++;
        end
        in_valid = 1'b0; start = 1'b0; force_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; base = '0; len = '0;
        in_valid = 1'b0; in_data = '0; mem_clr = 1'b1; force_en = 1'b0;
        force_idx = '0; force_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({in_ready, memWrite, memRead, busy, done, mismatch} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {in_ready, memWrite, memRead, busy, done, mismatch}); end
        n_cmp++; if (addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
        n_cmp++; if (data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data); end
        reset = 1'b1; mem_clr = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        n_cmp++; if ({busy, done, memWrite} !== 3'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, memWrite}); end
    endtask

    task automatic test_reset_midload();
        int i;
        bit hit;
        clear_mem();
        @(negedge clk); start = 1'b1; base = 5'd0; len = 6'd8;
        @(posedge clk);
        i = 0; hit = 1'b0;
        while (i < 20) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i);
            #1;
            if (memWrite && addr == 32'd3) begin hit = 1'b1; break; end
            @(posedge clk);
            i++;
        end
        n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL midload_reach_slot3: got %0d expected 1", hit); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({busy, memWrite, in_ready} !== 3'b0) begin
            n_fail++; $display("FAIL async_reset_drop: got %b expected 000", {busy, memWrite, in_ready}); end
        n_cmp++; if (addr !== 32'd0) begin n_fail++; $display("FAIL async_reset_addr: got %h expected 0", addr); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", busy); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (mem[k] !== 32'hA000_0000 + 32'(k)) begin
                n_fail++; $display("FAIL kept_slot%0d: got %h expected %h", k, mem[k], 32'hA000_0000 + 32'(k)); end
        end
        n_cmp++; if (mem[3] !== 32'd0) begin n_fail++; $display("FAIL slot3_unwritten: got %h expected 0", mem[3]); end
    endtask

    task automatic test_basic();
        clear_mem();
        run_load(5'd0, 6'd8, 1'b0, 32'h0120_0334, 1'b0, 1'b0);
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
        n_cmp++; if (nwr !== 8) begin n_fail++; $display("FAIL basic_writes: got %0d expected 8", nwr); end
        n_cmp++; if (wrseq !== 8'hFF) begin n_fail++; $display("FAIL basic_consecutive: got %b expected 11111111", wrseq); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            n_cmp++; if (wq[i] !== 5'(i) || dq[i] !== 32'h0120_0334 + 32'(i)) begin
                n_fail++; $display("FAIL basic_write%0d: got %0d/%h expected %0d/%h", i, wq[i], dq[i], i, 32'h0120_0334 + 32'(i)); end
        end
        n_cmp++; if (nrd !== (c_VERIFY ? 8 : 0)) begin n_fail++; $display("FAIL basic_reads: got %0d expected %0d", nrd, c_VERIFY ? 8 : 0); end
        for (int i = 0; i < 8 && i < rq.size(); i++) begin
            n_cmp++; if (rq[i] !== 5'(i)) begin n_fail++; $display("FAIL basic_read%0d: got %0d expected %0d", i, rq[i], i); end
        end
        n_cmp++; if (lat !== (c_VERIFY ? 17 : 9)) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, c_VERIFY ? 17 : 9); end
        n_cmp++; if (done_width !== 1) begin n_fail++; $display("FAIL basic_done_width: got %0d expected 1", done_width); end
        n_cmp++; if (mis_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_mismatch: got %b expected 0", mis_at_done); end
        n_cmp++; if (overlap !== 0) begin n_fail++; $display("FAIL basic_rw_overlap: got %0d expected 0", overlap); end
        n_cmp++; if (mem[5] !== 32'h0120_0339) begin n_fail++; $display("FAIL basic_slot5: got %h expected 01200339", mem[5]); end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_a [4];
        exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
        run_load(5'd30, 6'd4, 1'b0, 32'h5555_0000, 1'b0, 1'b0);
        n_cmp++; if (nwr !== 4) begin n_fail++; $display("FAIL wrap_writes: got %0d expected 4", nwr); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            n_cmp++; if (wq[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_waddr%0d: got %0d expected %0d", i, wq[i], exp_a[i]); end
        end
        n_cmp++; if (nrd !== (c_VERIFY ? 4 : 0)) begin n_fail++; $display("FAIL wrap_reads: got %0d expected %0d", nrd, c_VERIFY ? 4 : 0); end
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            n_cmp++; if (rq[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_raddr%0d: got %0d expected %0d", i, rq[i], exp_a[i]); end
        end
        n_cmp++; if (mem[1] !== 32'h5555_0003) begin n_fail++; $display("FAIL wrap_slot1: got %h expected 55550003", mem[1]); end
    endtask

    task automatic test_backpressure();
        run_load(5'd10, 6'd2, 1'b1, 32'h7700_0010, 1'b0, 1'b0);
        n_cmp++; if (wrseq[3:0] !== 4'b0101) begin n_fail++; $display("FAIL bp_write_pattern: got %b expected 0101", wrseq[3:0]); end
        n_cmp++; if (nwr !== 2) begin n_fail++; $display("FAIL bp_writes: got %0d expected 2", nwr); end
        n_cmp++; if (wq.size() == 2 && (wq[0] !== 5'd10 || wq[1] !== 5'd11)) begin
            n_fail++; $display("FAIL bp_addrs: got %0d,%0d expected 10,11", wq[0], wq[1]); end
        n_cmp++; if (mem[11] !== 32'h7700_0011) begin n_fail++; $display("FAIL bp_slot11: got %h expected 77000011", mem[11]); end
        n_cmp++; if (lat !== (c_VERIFY ? 6 : 4)) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, c_VERIFY ? 6 : 4); end
        n_cmp++; if (mis_at_done !== 1'b0) begin n_fail++; $display("FAIL bp_mismatch: got %b expected 0", mis_at_done); end
    endtask

    task automatic test_corruption();
        run_load(5'd0, 6'd4, 1'b0, 32'h1111_0000, 1'b1, 1'b0);
        n_cmp++; if (mis_at_done !== c_VERIFY) begin n_fail++; $display("FAIL corrupt_mismatch: got %b expected %b", mis_at_done, c_VERIFY); end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (mismatch !== c_VERIFY) begin n_fail++; $display("FAIL corrupt_sticky: got %b expected %b", mismatch, c_VERIFY); end
        run_load(5'd2, 6'd1, 1'b0, 32'h2222_0000, 1'b0, 1'b0);
        n_cmp++; if (mis_after_start !== 1'b0) begin n_fail++; $display("FAIL corrupt_clear_on_start: got %b expected 0", mis_after_start); end
        n_cmp++; if (mis_at_done !== 1'b0) begin n_fail++; $display("FAIL clean_after_corrupt: got %b expected 0", mis_at_done); end
    endtask

    task automatic test_len_edges();
        logic [31:0] mask;
        int dup;
        run_load(5'd9, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL len0_latency: got %0d expected 1", lat); end
        n_cmp++; if (nwr + nrd !== 0) begin n_fail++; $display("FAIL len0_strobes: got %0d expected 0", nwr + nrd); end
        n_cmp++; if (done_width !== 1) begin n_fail++; $display("FAIL len0_done_width: got %0d expected 1", done_width); end

        clear_mem();
        run_load(5'd7, 6'd40, 1'b0, 32'hC000_0000, 1'b0, 1'b0);
        mask = '0; dup = 0;
        foreach (wq[i]) begin
            if (mask[wq[i]]) dup++;
            mask[wq[i]] = 1'b1;
        end
        n_cmp++; if (nwr !== 32) begin n_fail++; $display("FAIL len40_writes: got %0d expected 32", nwr); end
        n_cmp++; if (mask !== 32'hFFFF_FFFF || dup !== 0) begin
            n_fail++; $display("FAIL len40_coverage: got %h dup %0d expected ffffffff dup 0", mask, dup); end
        n_cmp++; if (mem[6] !== 32'hC000_001F) begin n_fail++; $display("FAIL len40_last_slot: got %h expected c000001f", mem[6]); end
        n_cmp++; if (nrd !== (c_VERIFY ? 32 : 0)) begin n_fail++; $display("FAIL len40_reads: got %0d expected %0d", nrd, c_VERIFY ? 32 : 0); end
        n_cmp++; if (lat !== (c_VERIFY ? 65 : 33)) begin n_fail++; $display("FAIL len40_latency: got %0d expected %0d", lat, c_VERIFY ? 65 : 33); end

        run_load(5'd4, 6'd5, 1'b0, 32'h3300_0000, 1'b0, 1'b1);
        n_cmp++; if (nwr !== 5) begin n_fail++; $display("FAIL busy_start_writes: got %0d expected 5", nwr); end
        n_cmp++; if (wq.size() == 5 && (wq[0] !== 5'd4 || wq[4] !== 5'd8)) begin
            n_fail++; $display("FAIL busy_start_addrs: got %0d..%0d expected 4..8", wq[0], wq[4]); end
        n_cmp++; if (lat !== (c_VERIFY ? 11 : 6)) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, c_VERIFY ? 11 : 6); end
    endtask

    initial begin
        test_reset();
        test_reset_midload();
        test_basic();
        test_wrap();
        test_backpressure();
        test_corruption();
        test_len_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
